// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch/decode definitions: FSM state encoding, instruction field positions, opcodes.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: not applicable.
package instr_fetch_unit_pkg;

  // Fetch FSM encoding; the values are fixed because other blocks decode them.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } fetch_state_t;

  // MIPS-style instruction field bit positions.
  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RS_HI     = 25;
  localparam int RS_LO     = 21;
  localparam int RT_HI     = 20;
  localparam int RT_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 11;
  localparam int SHAMT_HI  = 10;
  localparam int SHAMT_LO  = 6;
  localparam int FUNCT_HI  = 5;
  localparam int FUNCT_LO  = 0;
  localparam int IMM_HI    = 15;
  localparam int IMM_LO    = 0;

  // Opcodes shared with the control unit.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;

  // Memory is word addressed; the byte offset is dropped, never used to rotate data.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instr_field_split.sv
// Slices a latched instruction word into its opcode, register, shift, function and immediate fields.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow instr directly.
module instr_field_split
  import instr_fetch_unit_pkg::*;
(
  input  logic [31:0] instr,
  output logic [5:0]  OPCODE,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16
);

  assign OPCODE = instr[OPCODE_HI:OPCODE_LO];
  assign rs     = instr[RS_HI:RS_LO];
  assign rt     = instr[RT_HI:RT_LO];
  assign rd     = instr[RD_HI:RD_LO];
  assign shamt  = instr[SHAMT_HI:SHAMT_LO];
  assign funct  = instr[FUNCT_HI:FUNCT_LO];
  assign imm16  = instr[IMM_HI:IMM_LO];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: reads the word at pc from synchronous memory, latches it and exposes decoded fields.
// Latency: fetch_done is high in the cycle after edge start+MEM_LATENCY; a start in DONE adds no bubble.
// Backpressure: none; fetch_start is dropped while WAIT, flush aborts. Option macro: FETCH_ALIGN_CHECK_EN.
module instr_fetch_unit #(
  parameter int MEM_LATENCY = 2  // 1..15 cycles from mem_rd first high to mem_rdata valid
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_start,
  input  logic        flush,
  input  logic [31:0] pc,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic [31:0] instr,
  output logic [5:0]  OPCODE,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [31:0] pc_plus4,
  output logic        busy,
  output logic        fetch_done,
  output logic        align_err
);
  import instr_fetch_unit_pkg::*;

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  fetch_state_t     state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             accept;   // start taken with a memory read: latch address and pc+4
  logic             capture;  // last WAIT cycle: memory data is valid now
`ifdef FETCH_ALIGN_CHECK_EN
  logic             misalign; // start taken with a misaligned pc: skip the read
  logic             align_err_q;
`endif

  // Next state and datapath strobes; DONE accepts a new start exactly like IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    capture   = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    misalign  = 1'b0;
`endif
    case (state)
      ST_IDLE, ST_DONE: begin
        state_nxt = ST_IDLE;
        if (fetch_start && !flush) begin
`ifdef FETCH_ALIGN_CHECK_EN
          if (pc[1:0] != 2'b00) begin
            misalign  = 1'b1;
            state_nxt = ST_DONE;
          end else begin
`else
          begin
`endif
            accept    = 1'b1;
            cnt_nxt   = CNT_W'(MEM_LATENCY - 1);
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (flush) begin
          state_nxt = ST_IDLE;
        end else if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM state and latency counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Address, pc+4 and instruction latches; a flush leaves them untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr <= '0;
      pc_plus4 <= '0;
      instr    <= '0;
    end else begin
      if (accept) begin
        mem_addr <= word_align(pc);
        pc_plus4 <= pc + 32'd4;
      end
      if (capture) begin
        instr <= mem_rdata;
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  // Alignment error is held only for the DONE cycle that the misaligned start produced.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      align_err_q <= 1'b0;
    end else begin
      align_err_q <= misalign;
    end
  end
  assign align_err = align_err_q;
`else
  assign align_err = 1'b0;
`endif

  assign mem_rd     = (state == ST_WAIT);
  assign fetch_done = (state == ST_DONE);
  assign busy       = (state != ST_IDLE);

  instr_field_split u_split (
    .instr  (instr),
    .OPCODE (OPCODE),
    .rs     (rs),
    .rt     (rt),
    .rd     (rd),
    .shamt  (shamt),
    .funct  (funct),
    .imm16  (imm16)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: vector table plus hand sequences for multi-cycle corners.
// Two instances share stimulus: dut0 with MEM_LATENCY=2, dut1 with MEM_LATENCY=1.
// Each has its own memory model that drives valid data only in the last read cycle.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_start = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] pc = '0;

  logic [31:0] mem_rdata0, mem_addr0, instr0, pc_plus40;
  logic        mem_rd0, busy0, fetch_done0, align_err0;
  logic [5:0]  OPCODE0, funct0;
  logic [4:0]  rs0, rt0, rd0, shamt0;
  logic [15:0] imm160;

  logic [31:0] mem_rdata1, mem_addr1, instr1, pc_plus41;
  logic        mem_rd1, busy1, fetch_done1, align_err1;
  logic [5:0]  OPCODE1, funct1;
  logic [4:0]  rs1, rt1, rd1, shamt1;
  logic [15:0] imm161;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.MEM_LATENCY(2)) u_dut0 (
    .clk(clk), .reset(reset), .fetch_start(fetch_start), .flush(flush), .pc(pc),
    .mem_rdata(mem_rdata0), .mem_addr(mem_addr0), .mem_rd(mem_rd0), .instr(instr0),
    .OPCODE(OPCODE0), .rs(rs0), .rt(rt0), .rd(rd0), .shamt(shamt0), .funct(funct0),
    .imm16(imm160), .pc_plus4(pc_plus40), .busy(busy0), .fetch_done(fetch_done0),
    .align_err(align_err0)
  );

  instr_fetch_unit #(.MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .fetch_start(fetch_start), .flush(flush), .pc(pc),
    .mem_rdata(mem_rdata1), .mem_addr(mem_addr1), .mem_rd(mem_rd1), .instr(instr1),
    .OPCODE(OPCODE1), .rs(rs1), .rt(rt1), .rd(rd1), .shamt(shamt1), .funct(funct1),
    .imm16(imm161), .pc_plus4(pc_plus41), .busy(busy1), .fetch_done(fetch_done1),
    .align_err(align_err1)
  );

  // Memory contents
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'h2008_0005;
      32'h0000_0020: return 32'h0123_4567;
      default:       return {OP_LW, 26'd0} | a;
    endcase
  endfunction

  // Memory models: k counts consecutive cycles mem_rd has been high.
  int k0 = 0;
  int k1 = 0;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      k0 <= 0;
      k1 <= 0;
    end else begin
      k0 <= mem_rd0 ? k0 + 1 : 0;
      k1 <= mem_rd1 ? k1 + 1 : 0;
    end
  end
  assign mem_rdata0 = (mem_rd0 && k0 == 1) ? mem_word(mem_addr0) : 32'hDEAD_BEEF;
  assign mem_rdata1 = (mem_rd1 && k1 == 0) ? mem_word(mem_addr1) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [31:0] addr;
    logic [31:0] pc4;
  } vec_t;

  vec_t vq[$];

  // Single fetch on dut0 (MEM_LATENCY=2) with full output check at the done cycle.
  task automatic run_fetch(input vec_t v);
    int edges;
    int rd_hi;
    @(negedge clk);
    pc = v.pc;
    fetch_start = 1'b1;
    @(posedge clk);
    edges = 0;
    rd_hi = 0;
    @(negedge clk);
    fetch_start = 1'b0;
    while (!fetch_done0 && edges < 40) begin
      if (mem_rd0) rd_hi++;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk("latency", edges, 2);
    chk("rd_cycles", rd_hi, 2);
    chk("mem_addr", mem_addr0, v.addr);
    chk("instr", instr0, v.instr);
    chk("OPCODE", {26'd0, OPCODE0}, {26'd0, v.op});
    chk("rs", {27'd0, rs0}, {27'd0, v.rs});
    chk("rt", {27'd0, rt0}, {27'd0, v.rt});
    chk("rd", {27'd0, rd0}, {27'd0, v.rd});
    chk("shamt", {27'd0, shamt0}, {27'd0, v.sh});
    chk("funct", {26'd0, funct0}, {26'd0, v.fn});
    chk("imm16", {16'd0, imm160}, {16'd0, v.imm});
    chk("pc_plus4", pc_plus40, v.pc4);
`ifndef FETCH_ALIGN_CHECK_EN
    chk("align_err_tied", {31'd0, align_err0}, 32'd0);
`endif
    @(negedge clk);
    chk("done_pulse", {31'd0, fetch_done0}, 32'd0);
    chk("instr_hold", instr0, v.instr);
    chk("busy_after", {31'd0, busy0}, 32'd0);
  endtask

  logic [31:0] b2b_pc[3];
  logic [31:0] b2b_instr[3];

  initial begin
    vec_t v;
    int   ndone, bubbles, cyc, edges, rd_hi, seen;
    logic after_done;

    b2b_pc[0] = 32'h10;          b2b_instr[0] = 32'h2008_0005;
    b2b_pc[1] = 32'h20;          b2b_instr[1] = 32'h0123_4567;
    b2b_pc[2] = 32'h100;         b2b_instr[2] = 32'h8C00_0100;

    v = '{32'h10, 32'h2008_0005, OP_ADDI, 5'd0, 5'd8, 5'd0, 5'd0, 6'h05, 16'h0005,
          32'h10, 32'h14};
    vq.push_back(v);
    v = '{32'h20, 32'h0123_4567, OP_RTYPE, 5'd9, 5'd3, 5'd8, 5'd21, 6'h27, 16'h4567,
          32'h20, 32'h24};
    vq.push_back(v);
    v = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3C, 16'hFFFC,
          32'hFFFF_FFFC, 32'h0};
    vq.push_back(v);
    v = '{32'h100, 32'h8C00_0100, OP_LW, 5'd0, 5'd0, 5'd0, 5'd4, 6'h00, 16'h0100,
          32'h100, 32'h104};
    vq.push_back(v);
`ifndef FETCH_ALIGN_CHECK_EN
    v = '{32'h6, 32'h8C00_0004, OP_LW, 5'd0, 5'd0, 5'd0, 5'd0, 6'h04, 16'h0004,
          32'h4, 32'hA};
    vq.push_back(v);
`endif

    // Reset state
    #12;
    chk("rst_instr", instr0, 32'd0);
    chk("rst_mem_addr", mem_addr0, 32'd0);
    chk("rst_pc_plus4", pc_plus40, 32'd0);
    chk("rst_flags", {28'd0, mem_rd0, fetch_done0, align_err0, busy0}, 32'd0);
    chk("rst_OPCODE", {26'd0, OPCODE0}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Vector table
    for (int i = 0; i < vq.size(); i++) run_fetch(vq[i]);

    // fetch_start during WAIT is ignored and not queued
    @(negedge clk);
    pc = 32'h10;
    fetch_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pc = 32'h20;
    @(negedge clk);
    fetch_start = 1'b0;
    @(negedge clk);
    chk("ign_done", {31'd0, fetch_done0}, 32'd1);
    chk("ign_instr", instr0, 32'h2008_0005);
    chk("ign_addr", mem_addr0, 32'h10);
    @(negedge clk);
    chk("ign_not_queued", {31'd0, busy0}, 32'd0);

    // Back-to-back fetches with fetch_start held high
    @(negedge clk);
    pc = b2b_pc[0];
    fetch_start = 1'b1;
    @(posedge clk);
    ndone = 0;
    bubbles = 0;
    cyc = 0;
    after_done = 1'b0;
    while (ndone < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (after_done) chk("b2b_rewait", {31'd0, mem_rd0}, 32'd1);
      after_done = 1'b0;
      if (!busy0) bubbles++;
      if (fetch_done0) begin
        chk("b2b_instr", instr0, b2b_instr[ndone]);
        ndone++;
        if (ndone < 3) begin
          pc = b2b_pc[ndone];
          after_done = 1'b1;
        end else begin
          fetch_start = 1'b0;
        end
      end
    end
    chk("b2b_count", ndone, 3);
    chk("b2b_bubbles", bubbles, 0);
    chk("b2b_cycles", cyc, 9);
    @(negedge clk);
    chk("b2b_idle", {31'd0, busy0}, 32'd0);

    // Flush in the second WAIT cycle
    @(negedge clk);
    pc = 32'h20;
    fetch_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fetch_start = 1'b0;
    chk("fl_wait1", {31'd0, mem_rd0}, 32'd1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_idle", {30'd0, busy0, mem_rd0}, 32'd0);
    chk("fl_nodone", {31'd0, fetch_done0}, 32'd0);
    chk("fl_instr_kept", instr0, 32'h8C00_0100);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (fetch_done0) seen++;
    end
    chk("fl_no_late_done", seen, 0);

    // Flush beats a coincident fetch_start
    @(negedge clk);
    flush = 1'b1;
    fetch_start = 1'b1;
    pc = 32'h10;
    @(negedge clk);
    flush = 1'b0;
    fetch_start = 1'b0;
    chk("fl_beats_start", {30'd0, busy0, mem_rd0}, 32'd0);

    // MEM_LATENCY=1 instance
    repeat (2) @(negedge clk);
    pc = 32'h20;
    fetch_start = 1'b1;
    @(posedge clk);
    edges = 0;
    rd_hi = 0;
    @(negedge clk);
    fetch_start = 1'b0;
    while (!fetch_done1 && edges < 40) begin
      if (mem_rd1) rd_hi++;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk("l1_latency", edges, 1);
    chk("l1_rd_cycles", rd_hi, 1);
    chk("l1_instr", instr1, 32'h0123_4567);
    chk("l1_pc_plus4", pc_plus41, 32'h24);
    repeat (4) @(negedge clk);

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned start: no read, one DONE cycle flagged, instr unchanged
    pc = 32'h6;
    fetch_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fetch_start = 1'b0;
    chk("al_err", {31'd0, align_err0}, 32'd1);
    chk("al_done", {31'd0, fetch_done0}, 32'd1);
    chk("al_no_rd", {31'd0, mem_rd0}, 32'd0);
    chk("al_instr", instr0, 32'h0123_4567);
    @(negedge clk);
    chk("al_clear", {30'd0, align_err0, busy0}, 32'd0);
    chk("al_no_rd2", {31'd0, mem_rd0}, 32'd0);
`endif

    // Async reset in the middle of WAIT
    @(negedge clk);
    pc = 32'h10;
    fetch_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fetch_start = 1'b0;
    chk("ar_in_wait", {31'd0, mem_rd0}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_instr", instr0, 32'd0);
    chk("ar_mem_addr", mem_addr0, 32'd0);
    chk("ar_pc_plus4", pc_plus40, 32'd0);
    chk("ar_flags", {28'd0, mem_rd0, fetch_done0, align_err0, busy0}, 32'd0);
    chk("ar_fields", {21'd0, OPCODE0, rs0}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (fetch_done0 || busy0) seen++;
    end
    chk("ar_no_done", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
